mvm_bn_res_epilogue: RTL and testbench

Per-channel epilogue stage directly downstream of the HBM MVM accumulator array. It consumes Tout-wide accumulator beats in output-layout order (channel group outer, pixel inner) and applies the per-channel BN scale and bias, an optional residual add and an optional ReLU. It then requantizes the result to activation width and streams it to the DDR write-back path. BN parameters and residual pixels arrive on their own streams, fetched by the existing BN-base and Res_Add-base readers.

---
 rtl/mvm_epi_pkg.sv | 36 +++
 rtl/mvm_bn_res_lane.sv | 71 +++++++
 rtl/mvm_bn_res_epilogue.sv | 150 +++++++++++++++
 tb/tb_mvm_bn_res_epilogue.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_epi_pkg.sv
// Shared types, default widths and the requantize helper for the MVM epilogue.
package mvm_epi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_BN,
        RUN,
        DRAIN
    } state_t;

    localparam int TOUT_DEF   = 32;
    localparam int ACC_DW_DEF = 32;
    localparam int BN_DW_DEF  = 16;
    localparam int DAT_DW_DEF = 16;

    // Arithmetic right shift (floor) followed by a clamp to a dw-bit signed range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] t,
        input logic [4:0]         sh,
        input int unsigned        dw
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = t >>> sh;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/mvm_bn_res_lane.sv
// Single-channel 3-stage epilogue datapath: multiply, bias/residual add, ReLU/requantize.
module bn_res_lane
    import mvm_epi_pkg::*;
#(
    parameter int ACC_DW = ACC_DW_DEF,
    parameter int BN_DW  = BN_DW_DEF,
    parameter int DAT_DW = DAT_DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ACC_DW-1:0] acc,
    input  logic [BN_DW-1:0]  w,
    input  logic [BN_DW-1:0]  b,
    input  logic [DAT_DW-1:0] res,
    input  logic [4:0]        wt_shift,
    input  logic [4:0]        bias_shift,
    input  logic [4:0]        res_shift,
    input  logic [4:0]        out_shift,
    input  logic              res_en,
    input  logic              relu_en,
    output logic [DAT_DW-1:0] y
);

    localparam int PW = ACC_DW + BN_DW;
    localparam int SW = PW + 2;

    logic signed [PW-1:0]     p_q;
    logic signed [BN_DW-1:0]  b_q;
    logic signed [DAT_DW-1:0] r_q;
    logic signed [SW-1:0]     t_q;
    logic [DAT_DW-1:0]        y_q;

    logic signed [SW-1:0]     p_ext;
    logic signed [SW-1:0]     b_ext;
    logic signed [SW-1:0]     r_ext;
    logic signed [SW-1:0]     t_d;
    logic signed [SW-1:0]     t_r;
    logic signed [63:0]       y_d;

    always_comb begin
        p_ext = {{(SW-PW){p_q[PW-1]}}, p_q};
        b_ext = {{(SW-BN_DW){b_q[BN_DW-1]}}, b_q};
        r_ext = {{(SW-DAT_DW){r_q[DAT_DW-1]}}, r_q};
        t_d   = (p_ext >>> wt_shift) + (b_ext <<< bias_shift);
        if (res_en)
            t_d = t_d + (r_ext <<< res_shift);
        t_r = (relu_en && t_q[SW-1]) ? '0 : t_q;
        y_d = sat_shift({{(64-SW){t_r[SW-1]}}, t_r}, out_shift, DAT_DW);
    end

    // Bias and residual ride along with the product so each stage owns its copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            b_q <= '0;
            r_q <= '0;
            t_q <= '0;
            y_q <= '0;
        end else if (en) begin
            p_q <= PW'($signed(acc)) * PW'($signed(w));
            b_q <= b;
            r_q <= res;
            t_q <= t_d;
            y_q <= DAT_DW'(y_d);
        end
    end

    assign y = y_q;

endmodule

// File: rtl/mvm_bn_res_epilogue.sv
// Per-channel BN scale/bias, optional residual add and ReLU, requantize; streams Tout-wide beats.
module mvm_bn_res_epilogue
    import mvm_epi_pkg::*;
#(
    parameter int TOUT   = TOUT_DEF,
    parameter int ACC_DW = ACC_DW_DEF,
    parameter int BN_DW  = BN_DW_DEF,
    parameter int DAT_DW = DAT_DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              cfg_pixels,
    input  logic [11:0]              cfg_groups,
    input  logic [4:0]               cfg_wt_shift,
    input  logic [4:0]               cfg_bias_shift,
    input  logic [4:0]               cfg_res_shift,
    input  logic [4:0]               cfg_out_shift,
    input  logic                     cfg_res_en,
    input  logic                     cfg_relu_en,
    input  logic                     bn_valid,
    output logic                     bn_ready,
    input  logic [TOUT*2*BN_DW-1:0]  bn_data,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  logic [TOUT*ACC_DW-1:0]   acc_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [TOUT*DAT_DW-1:0]   res_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TOUT*DAT_DW-1:0]   out_data,
    output logic                     busy,
    output logic                     done
);

    state_t state, state_nx;

    logic [15:0] pixels_q;
    logic [11:0] groups_q;
    logic [4:0]  wt_shift_q, bias_shift_q, res_shift_q, out_shift_q;
    logic        res_en_q, relu_en_q;
    logic [TOUT*2*BN_DW-1:0] bn_q;

    logic [15:0] pix_cnt;
    logic [11:0] grp_cnt;
    logic        s1_v, s2_v, s3_v;

    logic        pipe_en, fire, last_pix, last_grp, drain_done;

    assign pipe_en    = out_ready || !s3_v;
    assign fire       = (state == RUN) && acc_valid && (res_valid || !res_en_q) && pipe_en;
    assign last_pix   = (pix_cnt == pixels_q - 16'd1);
    assign last_grp   = (grp_cnt == groups_q - 12'd1);
    assign drain_done = (state == DRAIN) && !s1_v && !s2_v && (!s3_v || out_ready);

    always_comb begin
        state_nx  = state;
        bn_ready  = 1'b0;
        acc_ready = fire;
        res_ready = fire && res_en_q;
        busy      = (state != IDLE) || start;
        case (state)
            IDLE:    if (start) state_nx = LOAD_BN;
            LOAD_BN: begin
                bn_ready = 1'b1;
                if (bn_valid) state_nx = RUN;
            end
            RUN: begin
                if (fire && last_pix)
                    state_nx = last_grp ? DRAIN : LOAD_BN;
            end
            DRAIN:   if (drain_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pix_cnt <= '0;
            grp_cnt <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= drain_done;
            if (state == IDLE && start) begin
                pix_cnt <= '0;
                grp_cnt <= '0;
            end else if (fire) begin
                if (last_pix) begin
                    pix_cnt <= '0;
                    grp_cnt <= grp_cnt + 12'd1;
                end else begin
                    pix_cnt <= pix_cnt + 16'd1;
                end
            end
            if (pipe_en) begin
                s1_v <= fire;
                s2_v <= s1_v;
                s3_v <= s2_v;
            end
        end
    end

    // Configuration and BN word survive reset; they are reloaded by the next job anyway.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            pixels_q     <= cfg_pixels;
            groups_q     <= cfg_groups;
            wt_shift_q   <= cfg_wt_shift;
            bias_shift_q <= cfg_bias_shift;
            res_shift_q  <= cfg_res_shift;
            out_shift_q  <= cfg_out_shift;
            res_en_q     <= cfg_res_en;
            relu_en_q    <= cfg_relu_en;
        end
        if (state == LOAD_BN && bn_valid)
            bn_q <= bn_data;
    end

    assign out_valid = s3_v;

    for (genvar c = 0; c < TOUT; c++) begin : g_lane
        bn_res_lane #(
            .ACC_DW(ACC_DW),
            .BN_DW (BN_DW),
            .DAT_DW(DAT_DW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (pipe_en),
            .acc       (acc_data[c*ACC_DW +: ACC_DW]),
            .w         (bn_q[c*2*BN_DW +: BN_DW]),
            .b         (bn_q[c*2*BN_DW+BN_DW +: BN_DW]),
            .res       (res_data[c*DAT_DW +: DAT_DW]),
            .wt_shift  (wt_shift_q),
            .bias_shift(bias_shift_q),
            .res_shift (res_shift_q),
            .out_shift (out_shift_q),
            .res_en    (res_en_q),
            .relu_en   (relu_en_q),
            .y         (out_data[c*DAT_DW +: DAT_DW])
        );
    end

endmodule

// File: tb/tb_mvm_bn_res_epilogue.sv
// Self-checking bench: directed and randomized jobs against a plain-arithmetic epilogue model.
module tb_mvm_bn_res_epilogue;

    localparam int TOUT   = 32;
    localparam int ACC_DW = 32;
    localparam int BN_DW  = 16;
    localparam int DAT_DW = 16;
    localparam int OW     = TOUT*DAT_DW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [15:0]             cfg_pixels;
    logic [11:0]             cfg_groups;
    logic [4:0]              cfg_wt_shift, cfg_bias_shift, cfg_res_shift, cfg_out_shift;
    logic                    cfg_res_en, cfg_relu_en;
    logic                    bn_valid, bn_ready;
    logic [TOUT*2*BN_DW-1:0] bn_data;
    logic                    acc_valid, acc_ready;
    logic [TOUT*ACC_DW-1:0]  acc_data;
    logic                    res_valid, res_ready;
    logic [TOUT*DAT_DW-1:0]  res_data;
    logic                    out_valid, out_ready;
    logic [OW-1:0]           out_data;
    logic                    busy, done;

    mvm_bn_res_epilogue #(
        .TOUT  (TOUT),
        .ACC_DW(ACC_DW),
        .BN_DW (BN_DW),
        .DAT_DW(DAT_DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_pixels    (cfg_pixels),
        .cfg_groups    (cfg_groups),
        .cfg_wt_shift  (cfg_wt_shift),
        .cfg_bias_shift(cfg_bias_shift),
        .cfg_res_shift (cfg_res_shift),
        .cfg_out_shift (cfg_out_shift),
        .cfg_res_en    (cfg_res_en),
        .cfg_relu_en   (cfg_relu_en),
        .bn_valid      (bn_valid),
        .bn_ready      (bn_ready),
        .bn_data       (bn_data),
        .acc_valid     (acc_valid),
        .acc_ready     (acc_ready),
        .acc_data      (acc_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // job description
    int        c_pix, c_grp;
    logic [4:0] c_ws, c_bs, c_rs, c_os;
    bit        c_res, c_relu;
    bit        rnd_bp;

    logic [TOUT*2*BN_DW-1:0] bn_arr [8];
    logic [TOUT*ACC_DW-1:0]  acc_arr[64];
    logic [TOUT*DAT_DW-1:0]  res_arr[64];
    logic [OW-1:0]           exp_q[$];

    int bi, ai, ri;
    int done_cnt;
    bit bad_res;

    bit            prev_stall = 1'b0;
    logic [OW-1:0] prev_data;

    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: straight from the arithmetic rules, in 64-bit integers.
    function automatic longint ref_ch(longint a, longint w, longint b, longint r);
        longint t;
        t = ((a * w) >>> c_ws) + (b <<< c_bs);
        if (c_res) t = t + (r <<< c_rs);
        if (c_relu && t < 0) t = 0;
        t = t >>> c_os;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    task automatic build_expected(input int nb);
        logic [OW-1:0]         word;
        logic signed [31:0]    av;
        logic signed [15:0]    wv, bv, rv;
        longint                y;
        exp_q.delete();
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < TOUT; c++) begin
                av = acc_arr[k][c*ACC_DW +: ACC_DW];
                wv = bn_arr[k / c_pix][c*2*BN_DW +: BN_DW];
                bv = bn_arr[k / c_pix][c*2*BN_DW+BN_DW +: BN_DW];
                rv = res_arr[k][c*DAT_DW +: DAT_DW];
                y  = ref_ch(longint'(av), longint'(wv), longint'(bv), longint'(rv));
                word[c*DAT_DW +: DAT_DW] = 16'(y);
            end
            exp_q.push_back(word);
        end
    endtask

    task automatic drive_inputs();
        bn_valid  = (bi < c_grp) && (!rnd_bp || $urandom_range(0, 3) != 0);
        bn_data   = bn_arr[(bi < 8) ? bi : 0];
        acc_valid = (ai < c_pix*c_grp) && (!rnd_bp || $urandom_range(0, 3) != 0);
        acc_data  = acc_arr[(ai < 64) ? ai : 0];
        res_valid = (ri < c_pix*c_grp) && (!rnd_bp || $urandom_range(0, 2) != 0);
        res_data  = res_arr[(ri < 64) ? ri : 0];
        out_ready = !rnd_bp || ($urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset_mid();
        rst = 1'b1;
        start = 1'b0;
        bn_valid = 1'b0;
        acc_valid = 1'b0;
        res_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_readies", {bn_ready, acc_ready, res_ready}, 0);
        check("rst_out_data", out_data, 0);
        exp_q.delete();
    endtask

    task automatic run_job(input int abort_cyc);
        int nb;
        bit seen_done, hs_bn, hs_acc, hs_res;
        nb = c_pix * c_grp;
        build_expected(nb);
        bi = 0; ai = 0; ri = 0;
        done_cnt = 0;
        bad_res = 1'b0;
        seen_done = 1'b0;
        @(posedge clk); #1;
        cfg_pixels     = 16'(c_pix);
        cfg_groups     = 12'(c_grp);
        cfg_wt_shift   = c_ws;
        cfg_bias_shift = c_bs;
        cfg_res_shift  = c_rs;
        cfg_out_shift  = c_os;
        cfg_res_en     = c_res;
        cfg_relu_en    = c_relu;
        start = 1'b1;
        drive_inputs();
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            hs_bn  = bn_valid && bn_ready;
            hs_acc = acc_valid && acc_ready;
            hs_res = res_valid && res_ready;
            if (res_ready && !c_res) bad_res = 1'b1;
            if (done) begin
                seen_done = 1'b1;
                check("busy_at_done", busy, 0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (hs_bn)  bi++;
            if (hs_acc) ai++;
            if (hs_res) ri++;
            if (abort_cyc > 0 && cyc == abort_cyc) begin
                do_reset_mid();
                return;
            end
            drive_inputs();
        end
        if (!seen_done) check("job_timeout", seen_done, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("acc_beats", ai, nb);
        check("bn_words", bi, c_grp);
        check("done_pulses", done_cnt, 1);
        check("beats_left", exp_q.size(), 0);
        check("res_ready_off", bad_res, 0);
        if (c_res) check("res_beats", ri, nb);
    endtask

    task automatic fill_bn(input int g, input logic [15:0] w, input logic [15:0] b);
        for (int c = 0; c < TOUT; c++) bn_arr[g][c*2*BN_DW +: 2*BN_DW] = {b, w};
    endtask

    task automatic set_cfg(input int p, input int g, input int ws, input int bs, input int rs,
                           input int os, input bit re, input bit rl);
        c_pix = p; c_grp = g;
        c_ws = 5'(ws); c_bs = 5'(bs); c_rs = 5'(rs); c_os = 5'(os);
        c_res = re; c_relu = rl;
    endtask

    task automatic rand_job(input bit re, input bit rl, input int abort_cyc);
        logic [31:0] a;
        set_cfg(5, 3, $urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(0, 10),
                $urandom_range(0, 10), re, rl);
        for (int g = 0; g < 3; g++)
            for (int c = 0; c < TOUT; c++) bn_arr[g][c*2*BN_DW +: 2*BN_DW] = $urandom;
        for (int k = 0; k < 15; k++)
            for (int c = 0; c < TOUT; c++) begin
                a = $urandom;
                acc_arr[k][c*ACC_DW +: ACC_DW] = $signed(a) >>> $urandom_range(0, 24);
                res_arr[k][c*DAT_DW +: DAT_DW] = 16'($urandom);
            end
        rnd_bp = 1'b1;
        run_job(abort_cyc);
    endtask

    // Compare process: every out handshake against the model queue, plus hold-while-stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        bn_valid = 1'b0; acc_valid = 1'b0; res_valid = 1'b0; out_ready = 1'b0;
        bn_data = '0; acc_data = '0; res_data = '0;
        cfg_pixels = 16'd1; cfg_groups = 12'd1;
        cfg_wt_shift = '0; cfg_bias_shift = '0; cfg_res_shift = '0; cfg_out_shift = '0;
        cfg_res_en = 1'b0; cfg_relu_en = 1'b0;
        for (int k = 0; k < 64; k++) begin acc_arr[k] = '0; res_arr[k] = '0; end
        for (int g = 0; g < 8; g++) bn_arr[g] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_readies", {bn_ready, acc_ready, res_ready}, 0);
        check("reset_out_data", out_data, 0);

        // identity pass-through
        set_cfg(4, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        check("pin_identity", ref_ch(5, 1, 0, 0), 5);
        fill_bn(0, 16'd1, 16'd0);
        fill_bn(1, 16'd1, 16'd0);
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < TOUT; c++) acc_arr[k][c*ACC_DW +: ACC_DW] = k;
        rnd_bp = 1'b0;
        run_job(0);

        // BN scaling, both signs
        set_cfg(2, 1, 1, 2, 0, 0, 1'b0, 1'b0);
        check("pin_bn_pos", ref_ch(1000, 3, 5, 0), 1520);
        check("pin_bn_neg", ref_ch(-1000, 3, 5, 0), -1480);
        fill_bn(0, 16'd3, 16'd5);
        for (int c = 0; c < TOUT; c++) begin
            acc_arr[0][c*ACC_DW +: ACC_DW] = 1000;
            acc_arr[1][c*ACC_DW +: ACC_DW] = -1000;
        end
        run_job(0);

        // residual, then residual with ReLU
        for (int rl = 0; rl < 2; rl++) begin
            set_cfg(1, 1, 0, 0, 0, 0, 1'b1, rl[0]);
            check("pin_res", ref_ch(-100, 1, 0, 40), rl ? 0 : -60);
            fill_bn(0, 16'd1, 16'd0);
            for (int c = 0; c < TOUT; c++) begin
                acc_arr[0][c*ACC_DW +: ACC_DW] = -100;
                res_arr[0][c*DAT_DW +: DAT_DW] = 40;
            end
            run_job(0);
        end

        // saturation at both rails
        set_cfg(2, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        check("pin_sat_hi", ref_ch(64'sd1 <<< 30, 16384, 0, 0), 32767);
        check("pin_sat_lo", ref_ch(-(64'sd1 <<< 30), 16384, 0, 0), -32768);
        fill_bn(0, 16'd16384, 16'd0);
        for (int c = 0; c < TOUT; c++) begin
            acc_arr[0][c*ACC_DW +: ACC_DW] = 32'h4000_0000;
            acc_arr[1][c*ACC_DW +: ACC_DW] = 32'hC000_0000;
        end
        run_job(0);

        // randomized data, shifts and backpressure
        rand_job(1'b1, 1'b0, 0);
        rand_job(1'b1, 1'b1, 0);
        rand_job(1'b0, 1'b0, 0);

        // reset mid-run, then a fresh job
        rand_job(1'b1, 1'b0, 12);
        rand_job(1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
